if_fetch_unit: RTL and testbench

Instruction fetch stage for the RV32I core, directly upstream of the opcode/control decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions, each with its PC, in a small FIFO.
- Presents the instructions to decode over a valid/ready handshake.
- Accepts a redirect (taken branch, JAL or JALR target) that flushes buffered and in-flight fetches.

---
 rtl/rv32_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 tb/tb_if_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I fetch-side definitions: data widths, the canonical NOP and the
// fetch bundle that travels from instruction memory to decode.
package rv32_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_bundle_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch bundles with flush; flush wins over push.
// Also serves as the in-order address queue for in-flight fetch requests.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_bundle_t push_data_i,
    input  logic          pop_i,
    output fetch_bundle_t head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_bundle_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: credit-limited request issue, in-order response
// buffering and redirect handling that discards every fetch still in flight.
module if_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          dec_pop;
    logic [CW:0]   credit_used;

    fetch_bundle_t aq_head;
    logic [CW-1:0] outstanding;
    logic          aq_empty, aq_full;

    fetch_bundle_t df_head;
    logic [CW-1:0] df_count;
    logic          df_empty, df_full;

    // Buffered plus in-flight fetches may never exceed DEPTH, so the
    // instruction FIFO always has room for every response.
    assign credit_used    = {1'b0, df_count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_keep = imem_rsp_valid && !rsp_drop && !redirect_valid;

    assign dec_valid = !rst && !df_empty && !redirect_valid;
    assign dec_pop   = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? df_head.instr : INSTR_NOP;
    assign dec_pc    = dec_valid ? df_head.pc    : 32'h0000_0000;

    // Address queue is never flushed: stale fetches still return and are
    // matched off against drop_cnt.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_addr_q (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i ('{pc: pc_q, instr: 32'h0000_0000}),
        .pop_i       (imem_rsp_valid),
        .head_o      (aq_head),
        .count_o     (outstanding),
        .empty_o     (aq_empty),
        .full_o      (aq_full)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_instr_q (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (redirect_valid),
        .push_i      (rsp_keep),
        .push_data_i ('{pc: aq_head.pc, instr: imem_rsp_data}),
        .pop_i       (dec_pop),
        .head_o      (df_head),
        .count_o     (df_count),
        .empty_o     (df_empty),
        .full_o      (df_full)
    );

    logic unused_fifo_flags;
    assign unused_fifo_flags = ^{aq_head.instr, aq_empty, aq_full, df_full};

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            // Everything not yet returned is stale, including anything
            // arriving this very cycle.
            drop_cnt_d = outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_outstanding_max : assert property (@(posedge clk) disable iff (rst)
        outstanding <= CW'(DEPTH));
    a_credit_max : assert property (@(posedge clk) disable iff (rst)
        credit_used <= (CW + 1)'(DEPTH));
    a_drop_le_outstanding : assert property (@(posedge clk) disable iff (rst)
        drop_cnt_q <= outstanding);
    a_no_unexpected_rsp : assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small in-order instruction memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int mem_lat      = 1;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] fire_log[$];

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[31:2], 2'b11} ^ 32'hA5A5_0000;
    endfunction

    // Memory: decides the response for the coming edge, then logs a request
    // that will be accepted on that edge.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + 1 + mem_lat});
                fire_log.push_back(imem_req_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        fire_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1; mem_lat = 1;
        tick();
        samp();
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        tests_run++; if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        tests_run++; if (dec_instr !== NOP) begin tests_failed++; $display("FAIL reset_dec_instr: got %h expected %h", dec_instr, NOP); end
        tests_run++; if (dec_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_dec_pc: got %h expected 0", dec_pc); end
        tick();
        rst = 1'b0;
        samp();
        tests_run++; if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL post_reset_req_valid: got %b expected 1", imem_req_valid); end
        tests_run++; if (imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL post_reset_addr: got %h expected 0", imem_req_addr); end
        tests_run++; if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_dec_valid: got %b expected 0", dec_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        imem_req_ready = 1'b1; dec_ready = 1'b1; mem_lat = 1;
        do_reset();
        samp();
        tests_run++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_req0: got v=%b a=%h expected v=1 a=0", imem_req_valid, imem_req_addr); end
        tick(); samp();
        tests_run++; if (imem_req_addr !== 32'h4 || imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_req1: got v=%b a=%h expected v=1 a=4", imem_req_valid, imem_req_addr); end
        tests_run++; if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_dec_early: got %b expected 0", dec_valid); end
        tick(); samp();
        tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin tests_failed++; $display("FAIL stream_first_dec: got v=%b pc=%h expected v=1 pc=0", dec_valid, dec_pc); end
        tests_run++; if (dec_instr !== mem_word(32'h0)) begin tests_failed++; $display("FAIL stream_first_instr: got %h expected %h", dec_instr, mem_word(32'h0)); end
        exp_pc = 32'h4;
        for (int i = 0; i < 40 && exp_pc != 32'h18; i++) begin
            tick(); samp();
            if (dec_valid) begin
                tests_run++; if (dec_pc !== exp_pc || dec_instr !== mem_word(exp_pc)) begin tests_failed++; $display("FAIL stream_order: got pc=%h instr=%h expected pc=%h instr=%h", dec_pc, dec_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'h4;
            end
        end
        tests_run++; if (exp_pc !== 32'h18) begin tests_failed++; $display("FAIL stream_timeout: reached pc %h expected 18", exp_pc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        imem_req_ready = 1'b1; dec_ready = 1'b0; mem_lat = 1;
        do_reset();
        repeat (8) begin samp(); tick(); end
        samp();
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_blocked: got %b expected 0", imem_req_valid); end
        tests_run++; if (fire_log.size() != 2) begin tests_failed++; $display("FAIL bp_fire_count: got %0d expected 2", fire_log.size()); end
        else if (fire_log[0] !== 32'h0 || fire_log[1] !== 32'h4) begin tests_failed++; $display("FAIL bp_fire_addrs: got %h %h expected 0 4", fire_log[0], fire_log[1]); end
        tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin tests_failed++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", dec_valid, dec_pc); end
        tick();
        dec_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 30 && exp_pc != 32'hC; i++) begin
            samp();
            if (dec_valid) begin
                tests_run++; if (dec_pc !== exp_pc || dec_instr !== mem_word(exp_pc)) begin tests_failed++; $display("FAIL bp_drain: got pc=%h instr=%h expected pc=%h", dec_pc, dec_instr, exp_pc); end
                exp_pc = exp_pc + 32'h4;
            end
            tick();
        end
        tests_run++; if (exp_pc !== 32'hC) begin tests_failed++; $display("FAIL bp_timeout: reached pc %h expected c", exp_pc); end
        tests_run++; if (fire_log.size() < 3) begin tests_failed++; $display("FAIL bp_resume: got %0d fires expected >=3", fire_log.size()); end
        else if (fire_log[2] !== 32'h8) begin tests_failed++; $display("FAIL bp_resume_addr: got %h expected 8", fire_log[2]); end
    endtask

    task automatic test_redirect();
        logic found;
        imem_req_ready = 1'b1; dec_ready = 1'b1; mem_lat = 3;
        do_reset();
        samp(); tick();
        samp(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        samp();
        tests_run++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_cycle_quiet: got req=%b dec=%b expected 0 0", imem_req_valid, dec_valid); end
        tests_run++; if (fire_log.size() != 2) begin tests_failed++; $display("FAIL redir_inflight: got %0d expected 2", fire_log.size()); end
        fire_log.delete();
        tick();
        redirect_valid = 1'b0;
        samp();
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_credit_held: got %b expected 0", imem_req_valid); end
        tick(); samp();
        tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_new_req: got v=%b a=%h expected v=1 a=100", imem_req_valid, imem_req_addr); end
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(); samp();
            if (dec_valid) begin
                found = 1'b1;
                tests_run++; if (dec_pc !== 32'h100 || dec_instr !== mem_word(32'h100)) begin tests_failed++; $display("FAIL redir_first_dec: got pc=%h instr=%h expected pc=100 instr=%h", dec_pc, dec_instr, mem_word(32'h100)); end
            end
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL redir_timeout: got no dec_valid expected pc 100"); end
    endtask

    task automatic test_collision();
        logic found;
        imem_req_ready = 1'b1; dec_ready = 1'b1; mem_lat = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            samp();
            if (dec_valid && dec_pc == 32'h8 && imem_rsp_valid) found = 1'b1;
            else tick();
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL coll_setup: got no collision cycle expected head pc 8 with response"); end
        if (found) begin
            fire_log.delete();
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
            #1;
            tests_run++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL coll_no_pop: got dec=%b req=%b expected 0 0", dec_valid, imem_req_valid); end
            tick();
            redirect_valid = 1'b0;
            samp();
            tests_run++; if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL coll_fifo_empty: got %b expected 0", dec_valid); end
            found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                tick(); samp();
                if (dec_valid) begin
                    found = 1'b1;
                    tests_run++; if (dec_pc !== 32'h100) begin tests_failed++; $display("FAIL coll_next_pc: got %h expected 100", dec_pc); end
                end
            end
            tests_run++; if (!found) begin tests_failed++; $display("FAIL coll_timeout: got no dec_valid expected pc 100"); end
            tests_run++; if (fire_log.size() == 0 || fire_log[0] !== 32'h100) begin tests_failed++; $display("FAIL coll_first_req: got size %0d expected first addr 100", fire_log.size()); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [2];
        int          seen;
        exp_pcs[0] = 32'hFFFF_FFFC;
        exp_pcs[1] = 32'h0000_0000;
        imem_req_ready = 1'b1; dec_ready = 1'b1; mem_lat = 1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        samp();
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_redir_quiet: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        samp();
        tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_aligned: got v=%b a=%h expected v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
        tick(); samp();
        tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_rollover: got v=%b a=%h expected v=1 a=0", imem_req_valid, imem_req_addr); end
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            if (dec_valid) begin
                tests_run++; if (dec_pc !== exp_pcs[seen]) begin tests_failed++; $display("FAIL wrap_dec_pc: got %h expected %h", dec_pc, exp_pcs[seen]); end
                seen++;
            end
            tick(); samp();
        end
        tests_run++; if (seen != 2) begin tests_failed++; $display("FAIL wrap_timeout: got %0d outputs expected 2", seen); end
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b0; dec_ready = 1'b1; mem_lat = 1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            samp();
            tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL stall_hold_%0d: got v=%b a=%h expected v=1 a=0", i, imem_req_valid, imem_req_addr); end
            tick();
        end
        imem_req_ready = 1'b1;
        samp();
        tests_run++; if (imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL stall_accept_addr: got %h expected 0", imem_req_addr); end
        tick();
        imem_req_ready = 1'b0;
        samp();
        tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin tests_failed++; $display("FAIL stall_advance: got v=%b a=%h expected v=1 a=4", imem_req_valid, imem_req_addr); end
        tick(); samp();
        tests_run++; if (imem_req_addr !== 32'h4) begin tests_failed++; $display("FAIL stall_hold_again: got %h expected 4", imem_req_addr); end
        tests_run++; if (fire_log.size() != 1) begin tests_failed++; $display("FAIL stall_fire_count: got %0d expected 1", fire_log.size()); end
    endtask

    task automatic test_reset_mid();
        logic found;
        imem_req_ready = 1'b1; dec_ready = 1'b0; mem_lat = 3;
        do_reset();
        repeat (4) begin samp(); tick(); end
        rst = 1'b1;
        samp();
        tests_run++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_quiet: got req=%b dec=%b expected 0 0", imem_req_valid, dec_valid); end
        tick();
        rst = 1'b0;
        samp();
        tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL midrst_restart: got v=%b a=%h expected v=1 a=0", imem_req_valid, imem_req_addr); end
        dec_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(); samp();
            if (dec_valid) begin
                found = 1'b1;
                tests_run++; if (dec_pc !== 32'h0 || dec_instr !== mem_word(32'h0)) begin tests_failed++; $display("FAIL midrst_first_dec: got pc=%h instr=%h expected pc=0", dec_pc, dec_instr); end
            end
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL midrst_timeout: got no dec_valid expected pc 0"); end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_collision();
        test_wrap();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
